// File: rtl/imul_div_seq_pkg.sv
// -----------------------------------------------------------------------------
// imul_div_seq_pkg
// Shared definitions for the sequential restoring divider:
//   - div_state_e  : controller state encodings (DIV_ST_IDLE, DIV_ST_RUN)
//   - div_cnt_w()  : iteration counter width, clog2(SIZE)+1
//   - DIV_DBZ_FILL : fill bit of the divide-by-zero quotient (all ones)
// -----------------------------------------------------------------------------
package imul_div_seq_pkg;

    typedef enum logic [0:0] {
        DIV_ST_IDLE = 1'b0,
        DIV_ST_RUN  = 1'b1
    } div_state_e;

    // Replicated SIZE times to form the all-ones divide-by-zero quotient.
    localparam logic DIV_DBZ_FILL = 1'b1;

    // One extra bit so the counter can represent SIZE itself.
    function automatic int div_cnt_w(input int size);
        return $clog2(size) + 1;
    endfunction

endpackage

// File: rtl/imul_div_seq_div_step.sv
// -----------------------------------------------------------------------------
// imul_div_seq_div_step
// One combinational radix-2 restoring division iteration.
// Parameter:
//   SIZE       operand width (>= 2)
// Ports:
//   rem_i      working partial remainder
//   quo_i      working quotient / remaining dividend bits
//   divisor_i  divisor magnitude
//   rem_o      next partial remainder
//   quo_o      next quotient (new quotient bit shifted in at LSB)
// -----------------------------------------------------------------------------
module imul_div_seq_div_step #(
    parameter int SIZE = 16
) (
    input  logic [SIZE-1:0] rem_i,
    input  logic [SIZE-1:0] quo_i,
    input  logic [SIZE-1:0] divisor_i,
    output logic [SIZE-1:0] rem_o,
    output logic [SIZE-1:0] quo_o
);

    logic [SIZE:0] shifted;
    logic [SIZE:0] trial;
    logic          neg;

    always_comb begin
        // {rem,quo} shifted left by one: next dividend bit enters the remainder.
        shifted = {rem_i, quo_i[SIZE-1]};
        // Subtraction as A + ~B + 1, one bit wider so the MSB is the sign.
        trial   = shifted + ~{1'b0, divisor_i} + (SIZE+1)'(1);
        neg     = trial[SIZE];
        rem_o   = neg ? shifted[SIZE-1:0] : trial[SIZE-1:0];
        quo_o   = {quo_i[SIZE-2:0], ~neg};
    end

endmodule

// File: rtl/imul_div_seq.sv
// -----------------------------------------------------------------------------
// imul_div_seq
// Sequential radix-2 restoring divider, one quotient bit per clock under a
// Start/Done handshake. Latency is SIZE cycles from accepted Start to Done;
// a zero divisor completes in one cycle with DivByZero set.
// Optional build macro: DIV_SIGNED_EN -- two's complement operands, result
// truncated toward zero (quotient sign = XOR of signs, remainder takes the
// dividend's sign). Undefined: unsigned operation.
// Parameter:
//   SIZE       operand / result width (>= 2)
// Ports:
//   Clock      rising-edge clock
//   Reset      asynchronous active-high reset
//   Start      request, sampled only while idle
//   Dividend   numerator, latched on accepted Start
//   Divisor    denominator, latched on accepted Start
//   Quotient   result, held until the next completion
//   Remainder  result, held until the next completion
//   Busy       high while an iteration sequence is running
//   Done       one-cycle completion pulse
//   DivByZero  divide-by-zero flag of the last completed operation
// -----------------------------------------------------------------------------
module imul_div_seq
    import imul_div_seq_pkg::*;
#(
    parameter int SIZE = 16
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic            Start,
    input  logic [SIZE-1:0] Dividend,
    input  logic [SIZE-1:0] Divisor,
    output logic [SIZE-1:0] Quotient,
    output logic [SIZE-1:0] Remainder,
    output logic            Busy,
    output logic            Done,
    output logic            DivByZero
);

    localparam int CNT_W = div_cnt_w(SIZE);

    // Control and output registers (reset)
    div_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [SIZE-1:0]   quot_q, quot_d;
    logic [SIZE-1:0]   remo_q, remo_d;
    logic              done_q, done_d;
    logic              dbz_q, dbz_d;

    // Working datapath registers (no reset; loaded on accept)
    logic [SIZE-1:0]   wrem_q, wquo_q, wdvs_q;
`ifdef DIV_SIGNED_EN
    logic              sgnq_q, sgnr_q;
`endif

    logic              load;
    logic [SIZE-1:0]   rem_nxt, quo_nxt;

    // Operand magnitude; identity in the unsigned build.
    function automatic logic [SIZE-1:0] mag(input logic [SIZE-1:0] v);
`ifdef DIV_SIGNED_EN
        logic signed [SIZE-1:0] sv;
        sv = $signed(v);
        return (sv < 0) ? (~v + SIZE'(1)) : v;
`else
        return v;
`endif
    endfunction

    // Two's complement negation when s is set; the most-negative value wraps.
    function automatic logic [SIZE-1:0] neg_if(input logic [SIZE-1:0] v, input logic s);
        return s ? (~v + SIZE'(1)) : v;
    endfunction

    imul_div_seq_div_step #(.SIZE(SIZE)) u_step (
        .rem_i     (wrem_q),
        .quo_i     (wquo_q),
        .divisor_i (wdvs_q),
        .rem_o     (rem_nxt),
        .quo_o     (quo_nxt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        load    = 1'b0;
        case (state_q)
            DIV_ST_IDLE: begin
                if (Start) begin
                    if (Divisor == '0) begin
                        quot_d = {SIZE{DIV_DBZ_FILL}};
                        remo_d = Dividend;
                        dbz_d  = 1'b1;
                        done_d = 1'b1;
                    end else begin
                        state_d = DIV_ST_RUN;
                        cnt_d   = '0;
                        load    = 1'b1;
                    end
                end
            end
            DIV_ST_RUN: begin
                cnt_d = cnt_q + CNT_W'(1);
                // Last step: the step result goes straight into the outputs.
                if (cnt_q == CNT_W'(SIZE-1)) begin
                    state_d = DIV_ST_IDLE;
`ifdef DIV_SIGNED_EN
                    quot_d  = neg_if(quo_nxt, sgnq_q);
                    remo_d  = neg_if(rem_nxt, sgnr_q);
`else
                    quot_d  = neg_if(quo_nxt, 1'b0);
                    remo_d  = neg_if(rem_nxt, 1'b0);
`endif
                    dbz_d   = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: state_d = DIV_ST_IDLE;
        endcase
    end

    // Control / output register stage
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= DIV_ST_IDLE;
            cnt_q   <= '0;
            quot_q  <= '0;
            remo_q  <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    // Working register stage
    always_ff @(posedge Clock) begin
        if (load) begin
            wrem_q <= '0;
            wquo_q <= mag(Dividend);
            wdvs_q <= mag(Divisor);
`ifdef DIV_SIGNED_EN
            sgnq_q <= Dividend[SIZE-1] ^ Divisor[SIZE-1];
            sgnr_q <= Dividend[SIZE-1];
`endif
        end else if (state_q == DIV_ST_RUN) begin
            wrem_q <= rem_nxt;
            wquo_q <= quo_nxt;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = remo_q;
    assign Busy      = (state_q == DIV_ST_RUN);
    assign Done      = done_q;
    assign DivByZero = dbz_q;

endmodule

// File: tb/tb_imul_div_seq.sv
// -----------------------------------------------------------------------------
// tb_imul_div_seq
// Directed self-checking bench for imul_div_seq with SIZE=16.
// -----------------------------------------------------------------------------
module tb_imul_div_seq;

    localparam int SIZE = 16;

    logic            Clock = 1'b0;
    logic            Reset;
    logic            Start;
    logic [SIZE-1:0] Dividend;
    logic [SIZE-1:0] Divisor;
    logic [SIZE-1:0] Quotient;
    logic [SIZE-1:0] Remainder;
    logic            Busy;
    logic            Done;
    logic            DivByZero;

    int checks   = 0;
    int failures = 0;

    imul_div_seq #(.SIZE(SIZE)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .Start     (Start),
        .Dividend  (Dividend),
        .Divisor   (Divisor),
        .Quotient  (Quotient),
        .Remainder (Remainder),
        .Busy      (Busy),
        .Done      (Done),
        .DivByZero (DivByZero)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Present a request for one edge; returns Busy as seen just after it.
    task automatic issue(input logic [SIZE-1:0] dd, input logic [SIZE-1:0] dv, output logic busy_after);
        Start    = 1'b1;
        Dividend = dd;
        Divisor  = dv;
        tick();
        Start      = 1'b0;
        busy_after = Busy;
    endtask

    // Edges until Done is seen (bounded); -1 on timeout.
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!Done && cyc < 40);
        if (!Done) cyc = -1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        Start = 1'b0;
        Dividend = '0;
        Divisor  = '0;
        tick();
        tick();
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            failures++;
            $display("FAIL reset_state: got Q=%h R=%h B=%b D=%b Z=%b expected all zero",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        Reset = 1'b0;
        tick();
        checks++;
        if (Busy !== 1'b0 || Done !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_reset: got B=%b D=%b expected 0 0", Busy, Done);
        end
    endtask

    task automatic test_basic();
        logic b;
        int   cyc;
        issue(16'd100, 16'd7, b);
        checks++;
        if (b !== 1'b1) begin
            failures++;
            $display("FAIL basic_busy: got %b expected 1", b);
        end
        wait_done(cyc);
        checks++;
        if (cyc != SIZE) begin
            failures++;
            $display("FAIL basic_latency: got %0d expected %0d", cyc, SIZE);
        end
        checks++;
        if (Quotient !== 16'd14 || Remainder !== 16'd2 || DivByZero !== 1'b0 || Busy !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: got Q=%0d R=%0d Z=%b B=%b expected Q=14 R=2 Z=0 B=0",
                     Quotient, Remainder, DivByZero, Busy);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Quotient !== 16'd14 || Remainder !== 16'd2) begin
            failures++;
            $display("FAIL basic_hold: got D=%b Q=%0d R=%0d expected D=0 Q=14 R=2", Done, Quotient, Remainder);
        end
    endtask

    // Small directed table including dividend < divisor and MSB-set dividend.
    task automatic test_vectors();
        logic [SIZE-1:0] dd [3];
        logic [SIZE-1:0] dv [3];
        logic [SIZE-1:0] eq [3];
        logic [SIZE-1:0] er [3];
        logic b;
        int   cyc;
        dd[0] = 16'd5;    dv[0] = 16'd9;    eq[0] = 16'd0;    er[0] = 16'd5;
        dd[1] = 16'd9;    dv[1] = 16'd2;    eq[1] = 16'd4;    er[1] = 16'd1;
`ifdef DIV_SIGNED_EN
        dd[2] = 16'hFFFF; dv[2] = 16'h0010; eq[2] = 16'h0000; er[2] = 16'hFFFF;
`else
        dd[2] = 16'hFFFF; dv[2] = 16'h0010; eq[2] = 16'h0FFF; er[2] = 16'h000F;
`endif
        for (int i = 0; i < 3; i++) begin
            issue(dd[i], dv[i], b);
            wait_done(cyc);
            checks++;
            if (cyc != SIZE || Quotient !== eq[i] || Remainder !== er[i]) begin
                failures++;
                $display("FAIL vector_%0d: got cyc=%0d Q=%h R=%h expected cyc=%0d Q=%h R=%h",
                         i, cyc, Quotient, Remainder, SIZE, eq[i], er[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic b;
        int   cyc;
        issue(16'hFFFF, 16'h0001, b);
        wait_done(cyc);
        // Start presented while Done is visible must be accepted.
        Start    = 1'b1;
        Dividend = 16'h1234;
        Divisor  = 16'h1234;
        checks++;
        if (cyc != SIZE || Quotient !== 16'hFFFF || Remainder !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_first: got cyc=%0d Q=%h R=%h expected cyc=16 Q=ffff R=0000",
                     cyc, Quotient, Remainder);
        end
        tick();
        Start = 1'b0;
        checks++;
        if (Busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_accept: got Busy=%b expected 1", Busy);
        end
        wait_done(cyc);
        checks++;
        if (cyc != SIZE || Quotient !== 16'h0001 || Remainder !== 16'h0000) begin
            failures++;
            $display("FAIL b2b_second: got cyc=%0d Q=%h R=%h expected cyc=16 Q=0001 R=0000",
                     cyc, Quotient, Remainder);
        end
    endtask

    task automatic test_ignore_busy();
        logic b;
        int   first_done;
        issue(16'd50, 16'd3, b);
        first_done = -1;
        for (int i = 1; i <= SIZE + 2; i++) begin
            if (i == 5) begin
                Start    = 1'b1;
                Dividend = 16'd9;
                Divisor  = 16'd9;
            end
            tick();
            if (i == 5) Start = 1'b0;
            if (Done && first_done < 0) first_done = i;
            if (i == SIZE) begin
                checks++;
                if (Done !== 1'b1 || Quotient !== 16'd16 || Remainder !== 16'd2) begin
                    failures++;
                    $display("FAIL ignore_result: got D=%b Q=%0d R=%0d expected D=1 Q=16 R=2",
                             Done, Quotient, Remainder);
                end
            end
        end
        checks++;
        if (first_done != SIZE || Busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_timing: got first_done=%0d Busy=%b expected 16 0", first_done, Busy);
        end
    endtask

    task automatic test_div_zero();
        logic b;
        issue(16'h00AB, 16'h0000, b);
        checks++;
        if (Done !== 1'b1 || Quotient !== 16'hFFFF || Remainder !== 16'h00AB || DivByZero !== 1'b1 || b !== 1'b0) begin
            failures++;
            $display("FAIL divzero_result: got D=%b Q=%h R=%h Z=%b B=%b expected D=1 Q=ffff R=00ab Z=1 B=0",
                     Done, Quotient, Remainder, DivByZero, b);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || DivByZero !== 1'b1) begin
            failures++;
            $display("FAIL divzero_hold: got D=%b Z=%b expected D=0 Z=1", Done, DivByZero);
        end
    endtask

    task automatic test_reset_midrun();
        logic b;
        int   cyc;
        issue(16'd1000, 16'd10, b);
        repeat (7) tick();
        checks++;
        if (Busy !== 1'b1 || DivByZero !== 1'b1 || Quotient !== 16'hFFFF) begin
            failures++;
            $display("FAIL midrun_hold: got B=%b Z=%b Q=%h expected B=1 Z=1 Q=ffff", Busy, DivByZero, Quotient);
        end
        #2;
        Reset = 1'b1;
        #1;
        checks++;
        if ({Quotient, Remainder, Busy, Done, DivByZero} !== '0) begin
            failures++;
            $display("FAIL async_reset: got Q=%h R=%h B=%b D=%b Z=%b expected all zero",
                     Quotient, Remainder, Busy, Done, DivByZero);
        end
        tick();
        Reset = 1'b0;
        tick();
        issue(16'd9, 16'd2, b);
        wait_done(cyc);
        checks++;
        if (cyc != SIZE || Quotient !== 16'd4 || Remainder !== 16'd1 || DivByZero !== 1'b0) begin
            failures++;
            $display("FAIL after_reset: got cyc=%0d Q=%0d R=%0d Z=%b expected cyc=16 Q=4 R=1 Z=0",
                     cyc, Quotient, Remainder, DivByZero);
        end
    endtask

`ifdef DIV_SIGNED_EN
    task automatic test_signed();
        logic b;
        int   cyc;
        issue(16'hFFF9, 16'h0002, b);
        wait_done(cyc);
        checks++;
        if (Quotient !== 16'hFFFD || Remainder !== 16'hFFFF) begin
            failures++;
            $display("FAIL signed_neg7_div2: got Q=%h R=%h expected Q=fffd R=ffff", Quotient, Remainder);
        end
        issue(16'h8000, 16'hFFFF, b);
        wait_done(cyc);
        checks++;
        if (Quotient !== 16'h8000 || Remainder !== 16'h0000 || DivByZero !== 1'b0) begin
            failures++;
            $display("FAIL signed_minneg: got Q=%h R=%h Z=%b expected Q=8000 R=0000 Z=0",
                     Quotient, Remainder, DivByZero);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_vectors();
        test_back_to_back();
        test_ignore_busy();
        test_div_zero();
        test_reset_midrun();
`ifdef DIV_SIGNED_EN
        test_signed();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
